serial_tx_buffered: RTL and testbench

- Parametrised successor to the calculator's serial transmitter.
- Accepts result words from the ALU/memory path into a DEPTH-entry FIFO, then serialises each word on a single data line.
- Provides a programmable divided transmit clock, a selectable bit order, and back-to-back word streaming.
- Sits between the calculator datapath (result/memory read) and the top-level DataOut/clkTxOut pins.

---
 rtl/serial_tx_buffered.sv | 186 ++++++++++++++++++
 tb/tb_serial_tx_buffered.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_buffered.sv
// serial_tx_buffered
//   Buffers result words from the calculator datapath in a DEPTH-entry FIFO
//   and shifts each word out on a single data line. A transmit clock is
//   produced alongside the data so the receiver can sample dout on the rising
//   edge of clk_tx_out. Words are sent back-to-back, separated by one LOAD cycle.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-low reset
//   din        - word to transmit
//   din_valid  - din is offered; accepted when din_ready is also high
//   din_ready  - FIFO not full
//   freq_div   - new divider value D (0 behaves as 1)
//   config_div - load freq_div into the divider register (only honoured in IDLE)
//   busy       - transmitter active or FIFO not empty
//   dout_valid - dout carries a data bit
//   dout       - serial data
//   clk_tx_out - divided transmit clock: low D cycles, high D cycles per bit
//   fifo_count - words currently held in the FIFO
module serial_tx_buffered #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DIV_W     = 32,
  parameter int unsigned DIV_RST   = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          din,
  input  logic                       din_valid,
  output logic                       din_ready,
  input  logic [DIV_W-1:0]           freq_div,
  input  logic                       config_div,
  output logic                       busy,
  output logic                       dout_valid,
  output logic                       dout,
  output logic                       clk_tx_out,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              half_q, half_d;
  logic [DIV_W-1:0]  div_q, div_d;

  logic [DIV_W-1:0]  d_eff;
  logic              push;
  logic              pop;

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    half_d    = half_q;
    div_d     = div_q;
    pop       = 1'b0;

    // A divider of zero runs at the fastest rate, same as one.
    d_eff = (div_q == '0) ? DIV_W'(1) : div_q;
    push  = din_valid && (count_q != FULL_CNT);

    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (config_div) begin
          div_d = freq_div;
        end
        if (count_q != '0) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        pop       = 1'b1;
        shreg_d   = mem_q[rd_ptr_q];
        rd_ptr_d  = rd_ptr_q + AW'(1);
        bit_cnt_d = '0;
        div_cnt_d = '0;
        half_d    = 1'b0;
        state_d   = ST_SHIFT;
      end

      ST_SHIFT: begin
        // div_cnt counts D cycles per half bit; half_q selects the high half.
        if (div_cnt_q == d_eff - DIV_W'(1)) begin
          div_cnt_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              state_d = (count_q != '0) ? ST_LOAD : ST_IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
              if (MSB_FIRST != 0) begin
                shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
              end else begin
                shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
              end
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      half_q    <= 1'b0;
      div_q     <= DIV_W'(DIV_RST);
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      half_q    <= half_d;
      div_q     <= div_d;
    end
  end

  always_comb begin
    din_ready  = (count_q != FULL_CNT);
    busy       = (state_q != ST_IDLE) || (count_q != '0);
    dout_valid = (state_q == ST_SHIFT);
    clk_tx_out = (state_q == ST_SHIFT) && half_q;
    if (MSB_FIRST != 0) begin
      dout = (state_q == ST_SHIFT) && shreg_q[DATA_W-1];
    end else begin
      dout = (state_q == ST_SHIFT) && shreg_q[0];
    end
    fifo_count = count_q;
  end

endmodule

// File: tb/tb_serial_tx_buffered.sv
// tb_serial_tx_buffered
//   Bench for serial_tx_buffered: an MSB-first and an LSB-first instance.
//   Received words are reassembled from dout on rising clk_tx_out and compared
//   against a queue of pushed words.
module tb_serial_tx_buffered;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [31:0] freq_div = '0;
  logic        config_div = 1'b0;
  logic        busy;
  logic        dout_valid;
  logic        dout;
  logic        clk_tx_out;
  logic [2:0]  fifo_count;

  logic [15:0] l_din = '0;
  logic        l_din_valid = 1'b0;
  logic        l_din_ready;
  logic [31:0] l_freq_div = '0;
  logic        l_config_div = 1'b0;
  logic        l_busy;
  logic        l_dout_valid;
  logic        l_dout;
  logic        l_clk_tx_out;
  logic [2:0]  l_fifo_count;

  serial_tx_buffered #(
    .DATA_W(16), .DEPTH(4), .DIV_W(32), .DIV_RST(4), .MSB_FIRST(1)
  ) u_dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .freq_div(freq_div), .config_div(config_div),
    .busy(busy), .dout_valid(dout_valid), .dout(dout),
    .clk_tx_out(clk_tx_out), .fifo_count(fifo_count)
  );

  serial_tx_buffered #(
    .DATA_W(16), .DEPTH(4), .DIV_W(32), .DIV_RST(4), .MSB_FIRST(0)
  ) u_dut_lsb (
    .clk(clk), .reset(reset), .din(l_din), .din_valid(l_din_valid),
    .din_ready(l_din_ready), .freq_div(l_freq_div), .config_div(l_config_div),
    .busy(l_busy), .dout_valid(l_dout_valid), .dout(l_dout),
    .clk_tx_out(l_clk_tx_out), .fifo_count(l_fifo_count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned edge_no = 0;

  logic [15:0] sb_q[$];
  logic [15:0] l_sb_q[$];

  typedef struct {
    logic [15:0] word;
    logic [31:0] div;
    int unsigned period;
  } vec_t;

  vec_t vecs[4];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  always @(posedge clk) edge_no++;

  // MSB-first receiver model
  int unsigned m_nbits = 0;
  logic [15:0] m_acc = '0;
  logic        m_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      m_nbits = 0;
      m_prev  = 1'b0;
    end else begin
      if (dout_valid && clk_tx_out && !m_prev) begin
        m_acc = {m_acc[14:0], dout};
        m_nbits++;
        if (m_nbits == 16) begin
          m_nbits = 0;
          if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
          else chk("sb_word", 32'(m_acc), 32'(sb_q.pop_front()));
        end
      end
      m_prev = clk_tx_out;
    end
  end

  // LSB-first receiver model
  int unsigned l_nbits = 0;
  int unsigned l_words = 0;
  logic [15:0] l_acc = '0;
  logic        l_prev = 1'b0;
  logic        l_first = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      l_nbits = 0;
      l_prev  = 1'b0;
    end else begin
      if (l_dout_valid && l_clk_tx_out && !l_prev) begin
        if (l_nbits == 0 && l_words == 0) l_first = l_dout;
        l_acc = {l_dout, l_acc[15:1]};
        l_nbits++;
        if (l_nbits == 16) begin
          l_nbits = 0;
          l_words++;
          if (l_sb_q.size() == 0) chk("lsb_sb_underflow", 32'd1, 32'd0);
          else chk("lsb_sb_word", 32'(l_acc), 32'(l_sb_q.pop_front()));
        end
      end
      l_prev = l_clk_tx_out;
    end
  end

  // Stream statistics for the full-FIFO sequence
  bit          cnt_en = 1'b0;
  int unsigned gap_cnt = 0;
  int unsigned vcnt = 0;
  always @(negedge clk) begin
    if (cnt_en) begin
      if (busy && !dout_valid) gap_cnt++;
      if (dout_valid) vcnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(input logic [31:0] d);
    freq_div   = d;
    config_div = 1'b1;
    tick();
    config_div = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int unsigned bound);
    int unsigned n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    if (busy) chk(name, 32'd1, 32'd0);
  endtask

  // Push one word into an idle DUT and follow its transmission to the end.
  task automatic send_and_measure(input logic [15:0] w, input int unsigned period,
                                  input bit cfg_mid, input logic [31:0] mid_div,
                                  output int unsigned vlen, output int unsigned clk_err,
                                  output int unsigned lat);
    din       = w;
    din_valid = 1'b1;
    sb_q.push_back(w);
    tick();
    din_valid = 1'b0;
    lat = 0;
    while (!dout_valid && lat < 20) begin
      tick();
      lat++;
    end
    vlen    = 0;
    clk_err = 0;
    while (dout_valid && vlen < 4000) begin
      if (clk_tx_out !== 1'((vlen % period) >= (period / 2))) clk_err++;
      if (cfg_mid && vlen == 3) begin
        freq_div   = mid_div;
        config_div = 1'b1;
      end else begin
        config_div = 1'b0;
      end
      tick();
      vlen++;
    end
    config_div = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int unsigned vlen, clk_err, lat, base, waited;
    int unsigned acc_edge[6];
    logic [15:0] fw[6];

    vecs[0] = '{16'hA5C3, 32'd4, 8};
    vecs[1] = '{16'h5A3C, 32'd1, 2};
    vecs[2] = '{16'h8001, 32'd0, 2};
    vecs[3] = '{16'h1234, 32'd3, 6};

    // Reset and idle state
    reset = 1'b0;
    tick();
    tick();
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_dout", 32'(dout), 32'd0);
    chk("idle_dout_valid", 32'(dout_valid), 32'd0);
    chk("idle_clk_tx", 32'(clk_tx_out), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_din_ready", 32'(din_ready), 32'd1);
    chk("idle_fifo_count", 32'(fifo_count), 32'd0);

    // Single words across divider values
    for (int i = 0; i < 4; i++) begin
      set_div(vecs[i].div);
      send_and_measure(vecs[i].word, vecs[i].period, 1'b0, '0, vlen, clk_err, lat);
      chk("vec_latency", 32'(lat), 32'd2);
      chk("vec_valid_len", 32'(vlen), 32'(16 * vecs[i].period));
      chk("vec_clk_pattern_errs", 32'(clk_err), 32'd0);
      chk("vec_busy_after", 32'(busy), 32'd0);
      chk("vec_sb_empty", 32'(sb_q.size()), 32'd0);
    end

    // LSB-first instance
    l_din       = 16'h0001;
    l_din_valid = 1'b1;
    l_sb_q.push_back(16'h0001);
    tick();
    l_din = 16'hB00D;
    l_sb_q.push_back(16'hB00D);
    tick();
    l_din_valid = 1'b0;
    waited = 0;
    while (l_busy && waited < 1000) begin
      tick();
      waited++;
    end
    chk("lsb_idle", 32'(l_busy), 32'd0);
    chk("lsb_first_bit", 32'(l_first), 32'd1);
    chk("lsb_words", 32'(l_words), 32'd2);
    chk("lsb_sb_empty", 32'(l_sb_q.size()), 32'd0);

    // Full FIFO with continuous din_valid
    set_div(32'd4);
    fw[0] = 16'h1111; fw[1] = 16'h2222; fw[2] = 16'hC0DE;
    fw[3] = 16'h8421; fw[4] = 16'h7E81; fw[5] = 16'hFACE;
    gap_cnt = 0;
    vcnt    = 0;
    cnt_en  = 1'b1;
    base    = edge_no;
    for (int k = 0; k < 6; k++) begin
      din       = fw[k];
      din_valid = 1'b1;
      waited    = 0;
      while (!din_ready && waited < 500) begin
        tick();
        waited++;
      end
      if (!din_ready) chk("full_push_timeout", 32'd1, 32'd0);
      tick();
      sb_q.push_back(fw[k]);
      acc_edge[k] = edge_no - base - 1;
      if (k == 4) begin
        chk("full_fifo_count", 32'(fifo_count), 32'd4);
        chk("full_din_ready", 32'(din_ready), 32'd0);
      end
    end
    din_valid = 1'b0;
    chk("full_word4_edge", 32'(acc_edge[4]), 32'd4);
    chk("full_word5_edge", 32'(acc_edge[5]), 32'd132);
    wait_idle("full_idle_timeout", 2000);
    cnt_en = 1'b0;
    chk("full_gap_cycles", 32'(gap_cnt), 32'd7);
    chk("full_valid_cycles", 32'(vcnt), 32'd768);
    chk("full_sb_empty", 32'(sb_q.size()), 32'd0);

    // config_div ignored while transmitting, honoured in IDLE
    send_and_measure(16'h3C3C, 8, 1'b1, 32'd2, vlen, clk_err, lat);
    chk("cfgbusy_valid_len", 32'(vlen), 32'd128);
    chk("cfgbusy_clk_errs", 32'(clk_err), 32'd0);
    set_div(32'd2);
    send_and_measure(16'h9A6B, 4, 1'b0, '0, vlen, clk_err, lat);
    chk("cfgidle_valid_len", 32'(vlen), 32'd64);
    chk("cfgidle_clk_errs", 32'(clk_err), 32'd0);
    chk("cfg_sb_empty", 32'(sb_q.size()), 32'd0);
    set_div(32'd4);

    // Reset in the middle of a word with two words queued
    din_valid = 1'b1;
    din = 16'hDEAD; sb_q.push_back(din); tick();
    din = 16'hBEEF; sb_q.push_back(din); tick();
    din = 16'h0F0F; sb_q.push_back(din); tick();
    din_valid = 1'b0;
    waited = 0;
    while (!dout_valid && waited < 20) begin
      tick();
      waited++;
    end
    for (int c = 0; c < 40; c++) tick();
    chk("midrst_queued", 32'(fifo_count), 32'd2);
    chk("midrst_in_shift", 32'(dout_valid), 32'd1);
    reset = 1'b0;
    tick();
    chk("midrst_dout_valid", 32'(dout_valid), 32'd0);
    chk("midrst_fifo_count", 32'(fifo_count), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_clk_tx", 32'(clk_tx_out), 32'd0);
    chk("midrst_dout", 32'(dout), 32'd0);
    chk("midrst_din_ready", 32'(din_ready), 32'd1);
    sb_q.delete();
    reset = 1'b1;
    vlen = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (dout_valid || busy) vlen++;
    end
    chk("postrst_activity", 32'(vlen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
